gpr_scoreboard: RTL and testbench

- D-stage hazard tracker sitting beside the GPR file in the 5-stage MIPS pipeline.
- Keeps a shadow of the destination register, validity and remaining-latency (Tnew) for the instructions in E, M and W.
- Compares them with the D-stage source operands and their Tuse, then drives the pipeline stall and the D-stage forwarding selects for RS/RT.
- The W-stage writeback is covered by the GPR file's internal write-through bypass, so a W match never stalls and never forwards here.

---
 rtl/gpr_scoreboard.sv | 104 ++++++++++
 tb/tb_gpr_scoreboard.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gpr_scoreboard.sv
// D-stage hazard tracker: shadows E/M/W destinations and Tnew, drives stall and RS/RT forward selects.
// Optional stall-cycle counter enabled by defining GPR_SCOREBOARD_PERF_EN.
module gpr_scoreboard #(
    parameter int TW = 2,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_used,
    input  logic          d_rt_used,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          ext_stall,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic [AW-1:0] e_wa,
    output logic [AW-1:0] m_wa,
    output logic [AW-1:0] w_wa,
    output logic [31:0]   stall_cnt
);

    logic [AW-1:0] e_wa_q, m_wa_q, w_wa_q;
    logic [TW-1:0] e_tnew_q, m_tnew_q;
    logic [2:0]    rs_res, rt_res;

    // W needs no Tnew: a W hit is served by the GRF write-through bypass.
    function automatic logic [2:0] op_check(
        input logic [AW-1:0] s,
        input logic          used,
        input logic [TW-1:0] tuse,
        input logic [AW-1:0] ewa,
        input logic [TW-1:0] etn,
        input logic [AW-1:0] mwa,
        input logic [TW-1:0] mtn
    );
        logic       st;
        logic [1:0] sel;
        st  = 1'b0;
        sel = 2'd0;
        if (used && (s != '0)) begin
            if (ewa == s) begin
                if (etn > tuse)     st  = 1'b1;
                else if (etn == '0) sel = 2'd2;
            end else if (mwa == s) begin
                if (mtn > tuse)     st  = 1'b1;
                else if (mtn == '0) sel = 2'd1;
            end
        end
        return {st, sel};
    endfunction

    always_comb begin
        rs_res = op_check(d_rs, d_rs_used, d_rs_tuse, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        rt_res = op_check(d_rt, d_rt_used, d_rt_tuse, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
    end

    assign stall      = rs_res[2] | rt_res[2] | ext_stall;
    assign fwd_rs_sel = rs_res[1:0];
    assign fwd_rt_sel = rt_res[1:0];
    assign e_wa       = e_wa_q;
    assign m_wa       = m_wa_q;
    assign w_wa       = w_wa_q;

    // Shadows keep advancing while stalled; only a bubble enters E.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa_q   <= '0;
            e_tnew_q <= '0;
            m_wa_q   <= '0;
            m_tnew_q <= '0;
            w_wa_q   <= '0;
        end else begin
            w_wa_q   <= m_wa_q;
            m_wa_q   <= e_wa_q;
            m_tnew_q <= (e_tnew_q == '0) ? '0 : e_tnew_q - 1'b1;
            if (stall || (d_wa == '0)) begin
                e_wa_q   <= '0;
                e_tnew_q <= '0;
            end else begin
                e_wa_q   <= d_wa;
                e_tnew_q <= d_tnew;
            end
        end
    end

`ifdef GPR_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)      stall_cnt_q <= '0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Self-checking bench for gpr_scoreboard: directed pipeline scenarios plus random traffic vs a queue-style model.
module tb_gpr_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, d_wa;
    logic        d_rs_used, d_rt_used, ext_stall;
    logic [1:0]  d_rs_tuse, d_rt_tuse, d_tnew;
    logic        stall;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [4:0]  e_wa, m_wa, w_wa;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // model: index 0 = E, 1 = M, 2 = W
    int          mdl_wa[3];
    int          mdl_tnew[3];
    longint      mdl_cnt;
    bit          exp_stall;
    int          exp_rs_sel, exp_rt_sel;

    gpr_scoreboard #(.TW(2), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_wa(d_wa), .d_tnew(d_tnew),
        .ext_stall(ext_stall), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .e_wa(e_wa), .m_wa(m_wa), .w_wa(w_wa), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest-first search; only E and M hits can stall or forward.
    task automatic op_eval(input int s, input bit used, input int tuse, output bit st, output int sel);
        int hit;
        st  = 0;
        sel = 0;
        hit = -1;
        if (used && s != 0) begin
            for (int i = 0; i < 3; i++)
                if (hit < 0 && mdl_wa[i] == s) hit = i;
            if (hit == 0 || hit == 1) begin
                if (mdl_tnew[hit] > tuse)  st  = 1;
                else if (mdl_tnew[hit] == 0) sel = (hit == 0) ? 2 : 1;
            end
        end
    endtask

    task automatic set_d(input int rs, input bit rsu, input int rst, input int rt, input bit rtu,
                         input int rtt, input int wa, input int tn, input bit ext);
        d_rs = 5'(rs); d_rs_used = rsu; d_rs_tuse = 2'(rst);
        d_rt = 5'(rt); d_rt_used = rtu; d_rt_tuse = 2'(rtt);
        d_wa = 5'(wa); d_tnew = 2'(tn); ext_stall = ext;
    endtask

    // Called just after a negedge with inputs applied; returns at the following negedge.
    task automatic step();
        bit rs_st, rt_st;
        int exp_cnt;
        #1;
        op_eval(int'(d_rs), d_rs_used, int'(d_rs_tuse), rs_st, exp_rs_sel);
        op_eval(int'(d_rt), d_rt_used, int'(d_rt_tuse), rt_st, exp_rt_sel);
        exp_stall = rs_st | rt_st | ext_stall;
`ifdef GPR_SCOREBOARD_PERF_EN
        exp_cnt = int'(mdl_cnt % 64'h1_0000_0000);
`else
        exp_cnt = 0;
`endif
        chk("stall",      {31'd0, stall},      {31'd0, exp_stall});
        chk("fwd_rs_sel", {30'd0, fwd_rs_sel}, 32'(exp_rs_sel));
        chk("fwd_rt_sel", {30'd0, fwd_rt_sel}, 32'(exp_rt_sel));
        chk("e_wa",       {27'd0, e_wa},       32'(mdl_wa[0]));
        chk("m_wa",       {27'd0, m_wa},       32'(mdl_wa[1]));
        chk("w_wa",       {27'd0, w_wa},       32'(mdl_wa[2]));
        chk("stall_cnt",  stall_cnt,           32'(exp_cnt));
        @(posedge clk);
        if (reset) begin
            mdl_wa   = '{0, 0, 0};
            mdl_tnew = '{0, 0, 0};
            mdl_cnt  = 0;
        end else begin
            if (exp_stall) mdl_cnt++;
            mdl_wa[2]   = mdl_wa[1];
            mdl_tnew[2] = mdl_tnew[1];
            mdl_wa[1]   = mdl_wa[0];
            mdl_tnew[1] = (mdl_tnew[0] > 0) ? mdl_tnew[0] - 1 : 0;
            if (exp_stall || d_wa == 0) begin
                mdl_wa[0] = 0; mdl_tnew[0] = 0;
            end else begin
                mdl_wa[0] = int'(d_wa); mdl_tnew[0] = int'(d_tnew);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        mdl_wa = '{0, 0, 0}; mdl_tnew = '{0, 0, 0}; mdl_cnt = 0;
        reset = 1'b1;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        step();

        // lw $8 then dependent addu: two stall cycles, then the W hit needs no forward
        set_d(0, 0, 0, 0, 0, 0, 8, 2, 0); step();
        set_d(8, 1, 0, 0, 0, 0, 12, 1, 0);
        repeat (3) step();

        // addu $9 then beq on $9
        set_d(0, 0, 0, 0, 0, 0, 9, 1, 0); step();
        set_d(9, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();

        // ori $10 then subu reading rt=10 tuse=1: E forward
        set_d(0, 0, 0, 0, 0, 0, 10, 0, 0); step();
        set_d(0, 0, 0, 10, 1, 1, 13, 0, 0);
        #1; chk("ori_subu_rt_sel", {30'd0, fwd_rt_sel}, 32'd2);
        step();

        // $11 in both E and M with tnew 0: youngest (E) wins
        set_d(0, 0, 0, 0, 0, 0, 11, 1, 0); step();
        set_d(0, 0, 0, 0, 0, 0, 11, 0, 0); step();
        set_d(11, 1, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("youngest_wins", {30'd0, fwd_rs_sel}, 32'd2);
        step();

        // $0 destination never tracked; ext_stall drives the counter
        set_d(0, 0, 0, 0, 0, 0, 0, 3, 0); step();
        set_d(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        set_d(0, 1, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) step();
        reset = 1'b1; step();
        reset = 1'b0; set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // reset during an active lw stall
        set_d(0, 0, 0, 0, 0, 0, 8, 2, 0); step();
        set_d(8, 1, 0, 0, 0, 0, 12, 1, 0);
        reset = 1'b1; step();
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", {24'd0, stall, e_wa, m_wa, w_wa, fwd_rs_sel}, 32'd0);
        step();

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_d(int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), $urandom_range(0, 1) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
